// File: rtl/midi_pkg.sv
// Shared MIDI definitions: transmitter state encoding, status-byte range
// boundaries and the default bit period. Also holds the byte classifiers
// used by the running-status filter (MIDI_TX_RUNNING_STATUS_EN).
package midi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_t;

  // Lowest channel status, lowest system common and lowest real-time byte
  localparam logic [7:0] STATUS_MIN   = 8'h80;
  localparam logic [7:0] SYSCOM_MIN   = 8'hF0;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  // 32 clocks per bit at 1 MHz gives the MIDI rate of 31.25 kbaud
  localparam int DEFAULT_CLKS_PER_BIT = 32;

  function automatic logic is_channel_status(input logic [7:0] b);
    return (b >= STATUS_MIN) && (b < SYSCOM_MIN);
  endfunction

  function automatic logic is_system_common(input logic [7:0] b);
    return (b >= SYSCOM_MIN) && (b < REALTIME_MIN);
  endfunction

endpackage

// File: rtl/midi_baud_gen.sv
// Bit-period counter for MIDI serial links. Counts 0..CLKS_PER_BIT-1 and
// wraps; tc flags the last clock of a bit period. While clear is high the
// count is held at zero so a new period always starts aligned. Shared with
// the MIDI receivers.
module midi_baud_gen
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tc
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Free-running period counter, zeroed by clear and on terminal count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/midi_tx.sv
// MIDI OUT serializer. Pops bytes from the output FIFO with a one-cycle rd
// strobe and sends each as an 8N1 frame, LSB first, CLKS_PER_BIT clocks per
// bit. tx is registered from the current state, so the start bit falls two
// edges after empty_n is seen high.
// Optional feature: define MIDI_TX_RUNNING_STATUS_EN to drop channel status
// bytes that repeat the last transmitted status (MIDI running status).
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int WIDTH        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             empty_n,
  input  logic [WIDTH-1:0] data_i,
  output logic             rd,
  output logic             oe_n,
  output logic             tx,
  output logic             busy
);

  localparam logic [2:0] LAST_BIT = 3'(WIDTH - 1);

  tx_state_t        state;
  logic [WIDTH-1:0] shift_reg;
  logic [2:0]       bit_cnt;
  logic             baud_clear;
  logic             baud_tc;
  logic             suppress;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [WIDTH-1:0] last_status;

  assign suppress = is_channel_status(data_i) && (data_i == last_status);
`else
  assign suppress = 1'b0;
`endif

  // The FIFO output stays enabled for as long as the block is out of reset
  assign oe_n = reset;

  // Bit timing only runs while a frame is on the wire
  assign baud_clear = (state == ST_IDLE) || (state == ST_LOAD);

  midi_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tc   (baud_tc)
  );

  // Frame sequencer with registered rd, busy and tx
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rd        <= 1'b0;
      busy      <= 1'b0;
      tx        <= 1'b1;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
      last_status <= '0;
`endif
    end else begin
      case (state)
        ST_START: tx <= 1'b0;
        ST_DATA:  tx <= shift_reg[0];
        default:  tx <= 1'b1;
      endcase

      case (state)
        ST_IDLE: begin
          if (empty_n) begin
            state <= ST_LOAD;
            rd    <= 1'b1;
            busy  <= 1'b1;
          end
        end

        ST_LOAD: begin
          rd <= 1'b0;
          if (suppress) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            shift_reg <= data_i;
            bit_cnt   <= '0;
            state     <= ST_START;
          end
`ifdef MIDI_TX_RUNNING_STATUS_EN
          if (is_channel_status(data_i)) begin
            last_status <= data_i;
          end else if (is_system_common(data_i)) begin
            last_status <= '0;
          end
`endif
        end

        ST_START: begin
          if (baud_tc) begin
            state <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (baud_tc) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        ST_STOP: begin
          if (baud_tc) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          rd    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_tx.sv
// Self-checking bench for midi_tx. A queue-based FIFO model feeds the DUT,
// a line monitor decodes frames from tx, and a list-level reference model
// predicts which bytes leave the port and how far apart their start bits are.
// Honours MIDI_TX_RUNNING_STATUS_EN when it is defined for the build.
module tb_midi_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       empty_n = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       rd, oe_n, tx, busy;

  always #5 clk = ~clk;

  midi_tx #(.CLKS_PER_BIT(CPB), .WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .empty_n(empty_n),
    .data_i (data_i),
    .rd     (rd),
    .oe_n   (oe_n),
    .tx     (tx),
    .busy   (busy)
  );

  int checks = 0;
  int failures = 0;

  // FIFO model and monitor state
  logic [7:0] fifo_q[$];
  bit         pop_pending = 0;
  bit         do_pop;
  int         cycle = 0;
  int         rd_count = 0;
  int         rd_first_cycle = -1;
  int         rd_while_empty = 0;
  logic       prev_tx = 1'b1;
  bit         in_frame = 0;
  int         sidx = 0;
  logic       samples[FRAME];
  logic [7:0] mon_b;
  bit         mon_bad;
  logic [7:0] got_q[$];
  int         start_q[$];
  int         frame_err = 0;
  int         busy_run = 0;
  int         busy_runs[$];

  // Reference model outputs
  logic [7:0] exp_q[$];
  int         gap_q[$];
  logic [7:0] model_last = 8'h00;

  typedef struct {
    logic [63:0] ins;
    int          n;
    logic [63:0] exp_plain;
    int          n_plain;
    logic [63:0] exp_rs;
    int          n_rs;
  } vec_t;

  vec_t vecs[6];

  // FIFO model, rd bookkeeping, busy width and tx frame decoding
  always @(negedge clk) begin
    cycle++;
    if (reset) begin
      pop_pending = 0;
      in_frame    = 0;
      busy_run    = 0;
      prev_tx     = 1'b1;
    end else begin
      do_pop      = pop_pending;
      pop_pending = (rd === 1'b1);
      if (rd === 1'b1) begin
        if (!empty_n) rd_while_empty++;
        rd_count++;
        if (rd_first_cycle < 0) rd_first_cycle = cycle;
      end
      if (do_pop && fifo_q.size() > 0) fifo_q.delete(0);

      if (busy === 1'b1) begin
        busy_run++;
      end else if (busy_run > 0) begin
        busy_runs.push_back(busy_run);
        busy_run = 0;
      end

      if (!in_frame && prev_tx === 1'b1 && tx === 1'b0) begin
        in_frame = 1;
        sidx = 0;
        start_q.push_back(cycle);
      end
      if (in_frame) begin
        samples[sidx] = tx;
        sidx++;
        if (sidx == FRAME) begin
          mon_bad = 0;
          for (int i = 0; i < FRAME; i++) begin
            if (i < CPB) begin
              if (samples[i] !== 1'b0) mon_bad = 1;
            end else if (i >= 9 * CPB) begin
              if (samples[i] !== 1'b1) mon_bad = 1;
            end else if (samples[i] !== samples[CPB * (i / CPB)]) begin
              mon_bad = 1;
            end
          end
          for (int k = 0; k < 8; k++) mon_b[k] = samples[CPB * (k + 1)];
          if (mon_bad) frame_err++;
          got_q.push_back(mon_b);
          in_frame = 0;
        end
      end
      prev_tx = tx;
    end
    empty_n = (fifo_q.size() != 0);
    data_i  = empty_n ? fifo_q[0] : 8'h00;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearRecords();
    got_q.delete();
    start_q.delete();
    busy_runs.delete();
    rd_count       = 0;
    rd_first_cycle = -1;
    frame_err      = 0;
    model_last     = 8'h00;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick(3);
    fifo_q.delete();
    clearRecords();
    reset = 1'b0;
    tick(2);
  endtask

  task automatic applyStimulus(input logic [63:0] ins, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(ins[63 - 8 * i -: 8]);
  endtask

  // Which bytes are transmitted, and how many were swallowed before each
  task automatic modelRun(input logic [63:0] ins, input int n);
    logic [7:0] b;
    int skipped;
    skipped = 0;
    exp_q.delete();
    gap_q.delete();
    for (int i = 0; i < n; i++) begin
      b = ins[63 - 8 * i -: 8];
`ifdef MIDI_TX_RUNNING_STATUS_EN
      if (b >= 8'h80 && b <= 8'hEF) begin
        if (b == model_last) begin
          skipped++;
          continue;
        end
        model_last = b;
      end else if (b >= 8'hF0 && b <= 8'hF7) begin
        model_last = 8'h00;
      end
`endif
      exp_q.push_back(b);
      gap_q.push_back(skipped);
      skipped = 0;
    end
  endtask

  task automatic waitDone(input string name, input int n_pop);
    int budget;
    int waited;
    budget = n_pop * (FRAME + 4) + 60;
    waited = 0;
    while (!(rd_count >= n_pop && fifo_q.size() == 0 && busy === 1'b0 &&
             !in_frame && !pop_pending) && waited < budget) begin
      tick(1);
      waited++;
    end
    if (waited >= budget) checkOutput({name, "_timeout"}, 1, 0);
    tick(4);
  endtask

  task automatic checkRun(input string name, input int n_pop);
    checkOutput({name, "_rd_pulses"}, rd_count, n_pop);
    checkOutput({name, "_frames"}, got_q.size(), exp_q.size());
    checkOutput({name, "_framing"}, frame_err, 0);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      checkOutput({name, "_byte"}, got_q[i], exp_q[i]);
    for (int i = 1; i < start_q.size() && i < gap_q.size(); i++)
      checkOutput({name, "_start_gap"}, start_q[i] - start_q[i - 1],
                  FRAME + 2 + 2 * gap_q[i]);
  endtask

  task automatic setVec(input int idx, input logic [63:0] ins, input int n,
                        input logic [63:0] ep, input int np,
                        input logic [63:0] er, input int nr);
    vecs[idx].ins = ins;  vecs[idx].n = n;
    vecs[idx].exp_plain = ep; vecs[idx].n_plain = np;
    vecs[idx].exp_rs = er;    vecs[idx].n_rs = nr;
  endtask

  initial begin
    logic [63:0] rins;
    logic [63:0] ebytes;
    int          en;
    int          bad;
    int          waited;
    int          rn;

    setVec(0, 64'h90_00_00_00_00_00_00_00, 1,
              64'h90_00_00_00_00_00_00_00, 1,
              64'h90_00_00_00_00_00_00_00, 1);
    setVec(1, 64'h90_3C_64_00_00_00_00_00, 3,
              64'h90_3C_64_00_00_00_00_00, 3,
              64'h90_3C_64_00_00_00_00_00, 3);
    setVec(2, 64'h90_3C_64_90_40_00_F8_90, 8,
              64'h90_3C_64_90_40_00_F8_90, 8,
              64'h90_3C_64_40_00_F8_00_00, 6);
    setVec(3, 64'hF0_90_90_F7_90_00_00_00, 5,
              64'hF0_90_90_F7_90_00_00_00, 5,
              64'hF0_90_F7_90_00_00_00_00, 4);
    setVec(4, 64'h80_90_80_EF_EF_00_00_00, 5,
              64'h80_90_80_EF_EF_00_00_00, 5,
              64'h80_90_80_EF_00_00_00_00, 4);
    setVec(5, 64'hF8_C0_F8_C0_00_00_00_00, 4,
              64'hF8_C0_F8_C0_00_00_00_00, 4,
              64'hF8_C0_F8_00_00_00_00_00, 3);

    // Reset state
    reset = 1'b1;
    tick(3);
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_rd", rd, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_oe_n", oe_n, 1);
    reset = 1'b0;
    tick(1);
    checkOutput("run_oe_n", oe_n, 0);

    // Empty FIFO: the line must stay quiet
    bad = 0;
    repeat (200) begin
      tick(1);
      if (rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checkOutput("empty_idle", bad, 0);

    // Table-driven vectors
    for (int v = 0; v < 6; v++) begin
      doReset();
      modelRun(vecs[v].ins, vecs[v].n);
`ifdef MIDI_TX_RUNNING_STATUS_EN
      ebytes = vecs[v].exp_rs;
      en     = vecs[v].n_rs;
`else
      ebytes = vecs[v].exp_plain;
      en     = vecs[v].n_plain;
`endif
      exp_q.delete();
      for (int i = 0; i < en; i++) exp_q.push_back(ebytes[63 - 8 * i -: 8]);
      applyStimulus(vecs[v].ins, vecs[v].n);
      waitDone($sformatf("vec%0d", v), vecs[v].n);
      checkRun($sformatf("vec%0d", v), vecs[v].n);
      if (v == 0) begin
        checkOutput("first_latency",
                    (start_q.size() > 0) ? start_q[0] - rd_first_cycle : -1, 2);
        checkOutput("busy_width",
                    (busy_runs.size() > 0) ? busy_runs[0] : -1, FRAME + 1);
      end
      checkOutput($sformatf("vec%0d_tail_tx", v), tx, 1);
      checkOutput($sformatf("vec%0d_tail_empty", v), empty_n, 0);
    end

    // Reset during data bit 3 of 8'hA5 (bit 3 is 0 on the wire)
    doReset();
    applyStimulus(64'hA5_00_00_00_00_00_00_00, 1);
    waited = 0;
    while (rd_count == 0 && waited < 20) begin
      tick(1);
      waited++;
    end
    checkOutput("rst_pop_seen", rd_count, 1);
    tick(20);
    checkOutput("rst_pre_tx", tx, 0);
    checkOutput("rst_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("rst_async_tx", tx, 1);
    checkOutput("rst_async_busy", busy, 0);
    checkOutput("rst_async_oe_n", oe_n, 1);
    tick(3);
    clearRecords();
    reset = 1'b0;
    tick(10);
    checkOutput("rst_no_repop", rd_count, 0);
    checkOutput("rst_idle_tx", tx, 1);
    modelRun(64'h3C_00_00_00_00_00_00_00, 1);
    applyStimulus(64'h3C_00_00_00_00_00_00_00, 1);
    waitDone("rst_next", 1);
    checkRun("rst_next", 1);

    // Randomized streams against the reference model
    for (int r = 0; r < 8; r++) begin
      doReset();
      rn = $urandom_range(1, 8);
      rins = '0;
      for (int i = 0; i < rn; i++) begin
        case ($urandom_range(0, 5))
          0:       rins[63 - 8 * i -: 8] = 8'h90;
          1:       rins[63 - 8 * i -: 8] = 8'h91;
          2:       rins[63 - 8 * i -: 8] = 8'hF0 + 8'($urandom_range(0, 7));
          3:       rins[63 - 8 * i -: 8] = 8'hF8 + 8'($urandom_range(0, 7));
          4:       rins[63 - 8 * i -: 8] = 8'($urandom_range(0, 127));
          default: rins[63 - 8 * i -: 8] = 8'($urandom);
        endcase
      end
      modelRun(rins, rn);
      applyStimulus(rins, rn);
      waitDone($sformatf("rand%0d", r), rn);
      checkRun($sformatf("rand%0d", r), rn);
    end

    checkOutput("rd_while_empty", rd_while_empty, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
